// File: rtl/envelope_adsr.sv
// envelope_adsr: per-voice ADSR envelope generator driving oscillator.amplitude.
// Tracks a note gate and steps an internal level through attack, decay,
// sustain and release on sample_en ticks. Gate events are handled every clk.
//
// Optional feature macro: ENVELOPE_RESTART_ZERO_EN
//   defined     - a gate rising edge forces level to 0 (retrigger from silence)
//   not defined - a gate rising edge keeps the current level (click-free retrigger)
module envelope_adsr #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sample_en,
  input  logic             gate,
  input  logic [WIDTH-1:0] attack_step,
  input  logic [WIDTH-1:0] decay_step,
  input  logic [WIDTH-1:0] sustain_level,
  input  logic [WIDTH-1:0] release_step,
  output logic [WIDTH-1:0] amplitude,
  output logic             active
);

  localparam logic [WIDTH-1:0] PEAK = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] level;
  logic             gate_q;

  logic             gate_rise;
  logic             gate_fall;
  logic [WIDTH:0]   atk_sum;
  logic [WIDTH-1:0] dec_diff;
  logic             atk_done;
  logic             dec_done;
  logic             rel_done;

  // The level register is the amplitude output, so amplitude is registered
  // and lands on the edge that closes the sample_en cycle.
  assign amplitude = level;

  // Gate events and stage-completion tests; arithmetic is done wide enough
  // (or guarded by compares) so no stage can wrap.
  always_comb begin
    gate_rise = gate & ~gate_q;
    gate_fall = ~gate & ((state == ATTACK) | (state == DECAY) | (state == SUSTAIN));
    atk_sum   = {1'b0, level} + {1'b0, attack_step};
    dec_diff  = level - sustain_level;
    atk_done  = (attack_step == '0) | (atk_sum >= {1'b0, PEAK});
    // level <= sustain covers a sustain at or above the entry level.
    dec_done  = (decay_step == '0) | (level <= sustain_level) | (dec_diff <= decay_step);
    rel_done  = (release_step == '0) | (level <= release_step);
  end

  // Envelope FSM: gate events take priority and suppress stepping that cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      level  <= '0;
      gate_q <= 1'b0;
      active <= 1'b0;
    end else begin
      gate_q <= gate;
      if (gate_rise) begin
        state  <= ATTACK;
        active <= 1'b1;
`ifdef ENVELOPE_RESTART_ZERO_EN
        level  <= '0;
`endif
      end else if (gate_fall) begin
        state  <= RELEASE;
        active <= 1'b1;
      end else if (sample_en) begin
        case (state)
          IDLE: begin
            level  <= '0;
            active <= 1'b0;
          end
          ATTACK: begin
            if (atk_done) begin
              level <= PEAK;
              state <= DECAY;
            end else begin
              level <= atk_sum[WIDTH-1:0];
            end
          end
          DECAY: begin
            if (dec_done) begin
              level <= sustain_level;
              state <= SUSTAIN;
            end else begin
              level <= level - decay_step;
            end
          end
          SUSTAIN: begin
            // Re-read every tick so a live sustain change tracks.
            level <= sustain_level;
          end
          RELEASE: begin
            if (rel_done) begin
              level  <= '0;
              state  <= IDLE;
              active <= 1'b0;
            end else begin
              level <= level - release_step;
            end
          end
          default: begin
            level  <= '0;
            state  <= IDLE;
            active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_envelope_adsr.sv
// Scoreboard bench for envelope_adsr: each sample_en tick pushes the expected
// {active, amplitude}; a monitor pops and compares after the tick's clock edge.
module tb_envelope_adsr;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rstn;
  logic         sample_en;
  logic         gate;
  logic [W-1:0] attack_step, decay_step, sustain_level, release_step;
  logic [W-1:0] amplitude;
  logic         active;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  logic [W:0] exp_q[$];
  logic       mon_tick;
  logic [W:0] mon_exp;

  envelope_adsr #(.WIDTH(W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .sample_en    (sample_en),
    .gate         (gate),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .sustain_level(sustain_level),
    .release_step (release_step),
    .amplitude    (amplitude),
    .active       (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one sample tick (entered and left on a negedge), then 3 idle clocks.
  task automatic tick(input logic [W-1:0] ea, input logic eact);
    sample_en = 1'b1;
    exp_q.push_back({eact, ea});
    @(negedge clk);
    sample_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: a tick seen on a rising edge means the outputs are due 1 ns later.
  initial begin
    forever begin
      @(posedge clk);
      mon_tick = sample_en & rstn;
      #1;
      if (mon_tick) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          chk($sformatf("amp[%0d]", n_pop), {8'h0, amplitude}, {8'h0, mon_exp[W-1:0]});
          chk($sformatf("active[%0d]", n_pop), {31'h0, active}, {31'h0, mon_exp[W]});
          n_pop++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; gate = 1'b0; sample_en = 1'b0;
    attack_step = 24'h100000; decay_step = 24'h080000;
    sustain_level = 24'h800000; release_step = 24'h100000;
    repeat (2) @(negedge clk);
    chk("reset_amp", {8'h0, amplitude}, 32'h0);
    chk("reset_active", {31'h0, active}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Async reset in the middle of an attack.
    gate = 1'b1;
    @(negedge clk);
    chk("gate_to_attack_active", {31'h0, active}, 32'h1);
    for (int i = 1; i <= 3; i++) tick(W'(i * 24'h100000), 1'b1);
    #2 rstn = 1'b0; gate = 1'b0;
    #1;
    chk("async_reset_amp", {8'h0, amplitude}, 32'h0);
    chk("async_reset_active", {31'h0, active}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick(24'h0, 1'b0);

    // Attack to peak.
    gate = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 15; i++) tick(W'(i * 24'h100000), 1'b1);
    tick(24'hFFFFFF, 1'b1);

    // Decay to sustain, hold, and live sustain tracking.
    for (int k = 1; k <= 15; k++) tick(W'(24'hFFFFFF - k * 24'h080000), 1'b1);
    tick(24'h800000, 1'b1);
    tick(24'h800000, 1'b1);
    tick(24'h800000, 1'b1);
    sustain_level = 24'h900000;
    tick(24'h900000, 1'b1);
    sustain_level = 24'h800000;
    tick(24'h800000, 1'b1);

    // Release; the gate-fall cycle also carries a tick that must not step.
    gate = 1'b0;
    tick(24'h800000, 1'b1);
    for (int k = 7; k >= 1; k--) tick(W'(k * 24'h100000), 1'b1);
    tick(24'h0, 1'b0);

    // Retrigger during release at 0x400000.
    gate = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) tick(W'(i * 24'h100000), 1'b1);
    gate = 1'b0;
    @(negedge clk);
    gate = 1'b1;
    @(negedge clk);
`ifdef ENVELOPE_RESTART_ZERO_EN
    chk("retrigger_amp", {8'h0, amplitude}, 32'h0);
    tick(24'h100000, 1'b1);
`else
    chk("retrigger_amp", {8'h0, amplitude}, 32'h400000);
    tick(24'h500000, 1'b1);
`endif

    // Zero steps: instant attack, decay and release.
    attack_step = '0; decay_step = '0; release_step = '0; sustain_level = 24'h123456;
    tick(24'hFFFFFF, 1'b1);
    tick(24'h123456, 1'b1);
    tick(24'h123456, 1'b1);
    gate = 1'b0;
    @(negedge clk);
    tick(24'h0, 1'b0);

    // One-clock gate pulse: ATTACK then RELEASE on consecutive edges.
    gate = 1'b1;
    @(negedge clk);
    chk("pulse_attack_active", {31'h0, active}, 32'h1);
    gate = 1'b0;
    @(negedge clk);
    chk("pulse_release_active", {31'h0, active}, 32'h1);
    tick(24'h0, 1'b0);

    // sample_en held high: steps every clk, saturating at peak.
    attack_step = 24'h400000; decay_step = 24'h100000; sustain_level = 24'h800000;
    gate = 1'b1;
    @(negedge clk);
    sample_en = 1'b1;
    exp_q.push_back({1'b1, 24'h400000}); @(negedge clk);
    exp_q.push_back({1'b1, 24'h800000}); @(negedge clk);
    exp_q.push_back({1'b1, 24'hC00000}); @(negedge clk);
    exp_q.push_back({1'b1, 24'hFFFFFF}); @(negedge clk);
    exp_q.push_back({1'b1, 24'hEFFFFF}); @(negedge clk);
    sample_en = 1'b0;

    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
